hptdc_readout_emulator: RTL and testbench

Synthesizable HPTDC parallel-readout emulator. It drives the `hptdc_data`/`hptdc_data_ready`/`hptdc_get_data` readout port in place of a real HPTDC, and is used for board bring-up and for the USB data-path testbench. Each trigger produces one event: a header word, a programmable number of measurement words, and a trailer word. Measurement words carry type codes 0100/0101, so the downstream capture FIFO, which accepts `[31:29]==3'b010`, stores them.

---
 rtl/hptdc_readout_emulator.sv | 149 ++++++++++++++
 tb/tb_hptdc_readout_emulator.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hptdc_readout_emulator.sv
// hptdc_readout_emulator
//
// Stands in for a real HPTDC on its parallel readout port. Every trigger
// yields one event: a header word, HITS_PER_EVENT measurement words and a
// trailer word. Each word is presented with hptdc_data_ready and is followed
// by a one-cycle GAP, so every word has its own ready low->high edge.
//
// Ports
//   clk               system clock, rising edge
//   rst               asynchronous active-low reset
//   enable            permits new events to start (a running event completes)
//   trigger           one trigger per cycle sampled high
//   event_reset       synchronous clear of the event counter
//   bunch_reset       synchronous clear of the bunch counter
//   hptdc_get_data    receiver acknowledge
//   hptdc_data        readout word
//   hptdc_data_ready  word valid
//   busy              state is not IDLE
//   trig_overflow     sticky, set when a trigger is dropped
//   fsm_state         current FSM state encoding (debug)
//   pending           triggers waiting to start an event (debug)
//
// Handshake: a word transfers on a rising edge where hptdc_data_ready and
// hptdc_get_data are both high. While ready is high, hptdc_data is held
// stable for as long as the receiver withholds hptdc_get_data.
module hptdc_readout_emulator #(
  parameter logic [3:0]  TDC_ID         = 4'd0,
  parameter int          HITS_PER_EVENT = 4,
  parameter logic [18:0] TIME_STEP      = 19'd25
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        trigger,
  input  logic        event_reset,
  input  logic        bunch_reset,
  input  logic        hptdc_get_data,
  output logic [31:0] hptdc_data,
  output logic        hptdc_data_ready,
  output logic        busy,
  output logic        trig_overflow,
  output logic [2:0]  fsm_state,
  output logic [3:0]  pending
);

  typedef enum logic [2:0] {IDLE, HDR, HIT, TRL, GAP} state_t;

  localparam logic [4:0]  HITS5      = 5'(HITS_PER_EVENT);
  localparam logic [11:0] WORD_COUNT = 12'(HITS_PER_EVENT + 2);

  state_t      state, next_state;
  state_t      last_word;   // which word the current GAP follows
  logic [11:0] bunch_cnt, event_cnt, bid, eid;
  logic [4:0]  hit_idx;
  logic [3:0]  pend_cnt;
  logic        xfer, start, load_word;
  logic [18:0] hit_time;
  logic [31:0] next_word;

  assign hptdc_data_ready = (state == HDR) || (state == HIT) || (state == TRL);
  assign busy             = (state != IDLE);
  assign fsm_state        = state;
  assign pending          = pend_cnt;

  assign xfer     = hptdc_data_ready & hptdc_get_data;
  assign start    = (state == IDLE) && enable && (pend_cnt != 4'd0);
  assign hit_time = {bid, 7'b0} + 19'(hit_idx) * TIME_STEP;

  always_comb begin
    next_state = state;
    case (state)
      IDLE:          if (start) next_state = HDR;
      HDR, HIT, TRL: if (xfer)  next_state = GAP;
      GAP: begin
        case (last_word)
          HDR:     next_state = HIT;
          // hit_idx has already advanced past the hit just sent
          HIT:     next_state = (hit_idx < HITS5) ? HIT : TRL;
          default: next_state = IDLE;
        endcase
      end
      default:       next_state = IDLE;
    endcase
  end

  // The word register is loaded only when entering a word state, so it holds
  // through the word, the following GAP and any IDLE time.
  always_comb begin
    load_word = 1'b0;
    next_word = hptdc_data;
    if (start) begin
      load_word = 1'b1;
      // bid/eid are latched on this same edge, so use the live counters
      next_word = {4'b0010, TDC_ID, event_cnt, bunch_cnt};
    end else if (state == GAP && next_state == HIT) begin
      load_word = 1'b1;
      next_word = {3'b010, hit_idx[0], TDC_ID, hit_idx, hit_time};
    end else if (state == GAP && next_state == TRL) begin
      load_word = 1'b1;
      next_word = {4'b0011, TDC_ID, eid, WORD_COUNT};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      last_word     <= IDLE;
      bunch_cnt     <= '0;
      event_cnt     <= '0;
      bid           <= '0;
      eid           <= '0;
      hit_idx       <= '0;
      pend_cnt      <= '0;
      trig_overflow <= 1'b0;
      hptdc_data    <= '0;
    end else begin
      state <= next_state;
      if (xfer) last_word <= state;
      if (load_word) hptdc_data <= next_word;

      bunch_cnt <= bunch_reset ? 12'd0 : bunch_cnt + 12'd1;

      if (event_reset)
        event_cnt <= '0;
      else if (state == HDR && xfer)
        event_cnt <= event_cnt + 12'd1;

      if (start) begin
        bid     <= bunch_cnt;
        eid     <= event_cnt;
        hit_idx <= '0;
      end else if (state == HIT && xfer) begin
        hit_idx <= hit_idx + 5'd1;
      end

      // A trigger coinciding with an event start leaves the count unchanged,
      // even when the counter is full.
      if (trigger && !start) begin
        if (pend_cnt == 4'd15)
          trig_overflow <= 1'b1;
        else
          pend_cnt <= pend_cnt + 4'd1;
      end else if (!trigger && start) begin
        pend_cnt <= pend_cnt - 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_hptdc_readout_emulator.sv
module tb_hptdc_readout_emulator;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b0;
  logic        trigger = 1'b0;
  logic        event_reset = 1'b0;
  logic        bunch_reset = 1'b1;
  logic        hptdc_get_data;
  logic [31:0] hptdc_data;
  logic        hptdc_data_ready;
  logic        busy;
  logic        trig_overflow;
  logic [2:0]  fsm_state;
  logic [3:0]  pending;

  logic loop_mode  = 1'b1;
  logic get_manual = 1'b0;
  logic mon_en     = 1'b1;

  assign hptdc_get_data = loop_mode ? hptdc_data_ready : get_manual;

  always #5 clk = ~clk;

  hptdc_readout_emulator dut (
    .clk              (clk),
    .rst              (rst),
    .enable           (enable),
    .trigger          (trigger),
    .event_reset      (event_reset),
    .bunch_reset      (bunch_reset),
    .hptdc_get_data   (hptdc_get_data),
    .hptdc_data       (hptdc_data),
    .hptdc_data_ready (hptdc_data_ready),
    .busy             (busy),
    .trig_overflow    (trig_overflow),
    .fsm_state        (fsm_state),
    .pending          (pending)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Values sampled at the edge are the pre-edge word, i.e. the word transferred.
  always @(posedge clk) begin
    if (mon_en && hptdc_data_ready && hptdc_get_data) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL word_unexpected: got %h, expected no word", hptdc_data);
      end else begin
        check("word", hptdc_data, exp_q.pop_front());
      end
    end
  end

  function automatic logic [31:0] header_word(input int eid, input int bid);
    return {4'b0010, 4'd0, 12'(eid), 12'(bid)};
  endfunction

  function automatic logic [31:0] hit_word(input int bid, input int i);
    int t;
    t = (bid * 128 + i * 25) % 524288;
    return {3'b010, 1'(i % 2), 4'd0, 5'(i), 19'(t)};
  endfunction

  function automatic logic [31:0] trailer_word(input int eid);
    return {4'b0011, 4'd0, 12'(eid), 12'd6};
  endfunction

  task automatic push_event(input int eid, input int bid);
    exp_q.push_back(header_word(eid, bid));
    for (int i = 0; i < 4; i++) exp_q.push_back(hit_word(bid, i));
    exp_q.push_back(trailer_word(eid));
  endtask

  // ---------------- driver tasks ----------------
  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b0;
    enable = 1'b0;
    trigger = 1'b0;
    event_reset = 1'b0;
    exp_q.delete();
    repeat (3) @(negedge clk);
    check("rst_data", hptdc_data, 32'h0);
    check("rst_ready", hptdc_data_ready, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_overflow", trig_overflow, 1'b0);
    check("rst_pending", pending, 4'd0);
    rst = 1'b1;
  endtask

  task automatic pulse_trigger();
    @(negedge clk);
    trigger = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
  endtask

  task automatic wait_idle(input int max_cycles, input string name);
    int n;
    logic timed_out;
    n = 0;
    while ((busy || pending != 4'd0) && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    timed_out = busy || (pending != 4'd0);
    check(name, timed_out, 1'b0);
  endtask

  // ---------------- single-event vector table ----------------
  typedef struct {
    logic        trig;
    logic [31:0] data;
    logic        ready;
    logic        busy;
    logic [3:0]  pend;
  } vec_t;

  vec_t vecs[14];

  initial begin
    int n;
    vecs[0]  = '{1'b1, 32'h00000000, 1'b0, 1'b0, 4'd1};
    vecs[1]  = '{1'b0, 32'h20000000, 1'b1, 1'b1, 4'd0};
    vecs[2]  = '{1'b0, 32'h20000000, 1'b0, 1'b1, 4'd0};
    vecs[3]  = '{1'b0, 32'h40000000, 1'b1, 1'b1, 4'd0};
    vecs[4]  = '{1'b0, 32'h40000000, 1'b0, 1'b1, 4'd0};
    vecs[5]  = '{1'b0, 32'h50080019, 1'b1, 1'b1, 4'd0};
    vecs[6]  = '{1'b0, 32'h50080019, 1'b0, 1'b1, 4'd0};
    vecs[7]  = '{1'b0, 32'h40100032, 1'b1, 1'b1, 4'd0};
    vecs[8]  = '{1'b0, 32'h40100032, 1'b0, 1'b1, 4'd0};
    vecs[9]  = '{1'b0, 32'h5018004B, 1'b1, 1'b1, 4'd0};
    vecs[10] = '{1'b0, 32'h5018004B, 1'b0, 1'b1, 4'd0};
    vecs[11] = '{1'b0, 32'h30000006, 1'b1, 1'b1, 4'd0};
    vecs[12] = '{1'b0, 32'h30000006, 1'b0, 1'b1, 4'd0};
    vecs[13] = '{1'b0, 32'h30000006, 1'b0, 1'b0, 4'd0};

    apply_reset();

    // Single event, bunch counter held at 0, acknowledge looped back.
    @(negedge clk);
    enable = 1'b1;
    push_event(0, 0);
    for (int i = 0; i < 14; i++) begin
      trigger = vecs[i].trig;
      @(negedge clk);
      check($sformatf("vec%0d_data", i), hptdc_data, vecs[i].data);
      check($sformatf("vec%0d_ready", i), hptdc_data_ready, vecs[i].ready);
      check($sformatf("vec%0d_busy", i), busy, vecs[i].busy);
      check($sformatf("vec%0d_pending", i), pending, vecs[i].pend);
    end
    trigger = 1'b0;
    check("single_queue_empty", 32'(exp_q.size()), 32'd0);

    // Stall: header held while the receiver withholds acknowledge.
    loop_mode = 1'b0;
    get_manual = 1'b0;
    pulse_trigger();
    n = 0;
    while (!hptdc_data_ready && n < 5) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 20; i++) begin
      check("stall_data", hptdc_data, header_word(1, 0));
      check("stall_ready", hptdc_data_ready, 1'b1);
      @(negedge clk);
    end
    push_event(1, 0);
    get_manual = 1'b1;
    @(negedge clk);
    check("stall_gap_ready", hptdc_data_ready, 1'b0);
    @(negedge clk);
    check("stall_next_ready", hptdc_data_ready, 1'b1);
    check("stall_next_data", hptdc_data, hit_word(0, 0));
    loop_mode = 1'b1;
    wait_idle(40, "stall_idle_timeout");
    check("stall_queue_empty", 32'(exp_q.size()), 32'd0);

    // Overflow: 16 triggers while disabled, then drain 15 events.
    apply_reset();
    @(negedge clk);
    trigger = 1'b1;
    repeat (16) @(negedge clk);
    trigger = 1'b0;
    check("ovf_pending", pending, 4'd15);
    check("ovf_flag", trig_overflow, 1'b1);
    for (int e = 0; e < 15; e++) push_event(e, 0);
    enable = 1'b1;
    wait_idle(400, "ovf_idle_timeout");
    repeat (5) @(negedge clk);
    check("ovf_queue_empty", 32'(exp_q.size()), 32'd0);
    check("ovf_still_idle", busy, 1'b0);
    check("ovf_flag_sticky", trig_overflow, 1'b1);

    // event_reset on the header-transfer edge of event 3.
    apply_reset();
    @(negedge clk);
    trigger = 1'b1;
    repeat (5) @(negedge clk);
    trigger = 1'b0;
    push_event(0, 0);
    push_event(1, 0);
    push_event(2, 0);
    push_event(3, 0);
    push_event(0, 0);
    enable = 1'b1;
    n = 0;
    while (!(fsm_state == 3'd1 && hptdc_data[23:12] == 12'd3) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("evrst_found_hdr3", fsm_state, 3'd1);
    event_reset = 1'b1;
    @(negedge clk);
    event_reset = 1'b0;
    wait_idle(200, "evrst_idle_timeout");
    check("evrst_queue_empty", 32'(exp_q.size()), 32'd0);

    // Free-running bunch counter: start latched at 4095, plus a trigger
    // coinciding with the event start; the second event sees the wrap.
    push_event(1, 4095);
    push_event(2, 12);
    @(negedge clk);
    bunch_reset = 1'b1;
    @(negedge clk);
    bunch_reset = 1'b0;
    repeat (4094) @(posedge clk);
    @(negedge clk);
    trigger = 1'b1;
    @(negedge clk);
    @(negedge clk);
    trigger = 1'b0;
    check("simul_pending", pending, 4'd1);
    check("simul_busy", busy, 1'b1);
    wait_idle(100, "bunch_idle_timeout");
    check("bunch_queue_empty", 32'(exp_q.size()), 32'd0);
    bunch_reset = 1'b1;

    // Asynchronous reset in the middle of a hit word.
    mon_en = 1'b0;
    pulse_trigger();
    n = 0;
    while (fsm_state != 3'd2 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("arst_in_hit", fsm_state, 3'd2);
    #2;
    rst = 1'b0;
    #1;
    check("arst_ready", hptdc_data_ready, 1'b0);
    check("arst_busy", busy, 1'b0);
    check("arst_data", hptdc_data, 32'h0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b1;
    mon_en = 1'b1;
    repeat (10) @(negedge clk);
    check("arst_quiet_busy", busy, 1'b0);
    check("arst_quiet_pending", pending, 4'd0);
    push_event(0, 0);
    pulse_trigger();
    wait_idle(40, "arst_idle_timeout");
    check("arst_queue_empty", 32'(exp_q.size()), 32'd0);

    // ---------------- final report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
